risc8_fetch: RTL and testbench

RISC8_FETCH -- requirements
Module: risc8_fetch

---
 rtl/risc8_fetch.sv | 180 ++++++++++++++++++
 tb/tb_risc8_fetch.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc8_fetch.sv
// risc8_fetch: instruction fetch unit with two-word assembler
// and a 2-entry instruction FIFO feeding the decoder.
module risc8_fetch #(
   parameter int unsigned        PC_BITS      = 16,
   parameter logic [PC_BITS-1:0] RESET_VECTOR = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_BITS-1:0] pmem_addr,
   output logic               pmem_re,
   input  logic [15:0]        pmem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        opcode,
   output logic [15:0]        opcode2,
   output logic               two_word,
   output logic [PC_BITS-1:0] pc,
   output logic [PC_BITS-1:0] pc_next,
   input  logic               redirect_valid,
   input  logic [PC_BITS-1:0] redirect_addr
);

   localparam logic [PC_BITS-1:0] ONE = {{(PC_BITS-1){1'b0}}, 1'b1};
   localparam logic [PC_BITS-1:0] TWO = {{(PC_BITS-2){1'b0}}, 2'b10};

   typedef enum logic {W1, W2} asm_e;

   typedef struct packed {
      logic [15:0]        op;
      logic [15:0]        op2;
      logic               tw;
      logic [PC_BITS-1:0] pc;
   } entry_t;

   entry_t             fifo_q [2];
   entry_t             fifo_d [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;
   asm_e               state_q, state_d;
   logic               pend_q, pend_d;
   logic [PC_BITS-1:0] pend_pc_q, pend_pc_d;
   logic [PC_BITS-1:0] fetch_addr_q, fetch_addr_d;
   logic [PC_BITS-1:0] lat_pc_q, lat_pc_d;
   logic [15:0]        lat_op_q, lat_op_d;

   logic               pop;
   logic               push;
   logic               inflight;
   logic               issue;
   logic [2:0]         occ;
   entry_t             new_e;
   entry_t             head;

   function automatic logic is_two(input logic [15:0] w);
      logic lds_sts;
      logic jmp_call;
      lds_sts  = (w[15:9] == 7'b1001000 || w[15:9] == 7'b1001001)
                 && w[3:0] == 4'b0000;
      jmp_call = (w[15:9] == 7'b1001010) && (w[3:2] == 2'b11);
      return lds_sts || jmp_call;
   endfunction

   // Present the FIFO head; fields read as zero when nothing is valid
   always_comb begin
      head      = fifo_q[rd_ptr_q];
      out_valid = !reset && (count_q != 2'd0);
      opcode    = '0;
      opcode2   = '0;
      two_word  = 1'b0;
      pc        = '0;
      pc_next   = '0;
      if (out_valid) begin
         opcode   = head.op;
         opcode2  = head.op2;
         two_word = head.tw;
         pc       = head.pc;
         pc_next  = head.pc + (head.tw ? TWO : ONE);
      end
   end

   // Assembler FSM, FIFO bookkeeping, read issue and redirect handling
   always_comb begin
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      state_d      = state_q;
      pend_d       = 1'b0;
      pend_pc_d    = pend_pc_q;
      fetch_addr_d = fetch_addr_q;
      lat_pc_d     = lat_pc_q;
      lat_op_d     = lat_op_q;
      push         = 1'b0;
      new_e        = '0;
      pmem_re      = 1'b0;
      pmem_addr    = fetch_addr_q;

      pop      = out_valid && out_ready;
      inflight = pend_q || (state_q == W2);
      occ      = {1'b0, count_q} + {2'b00, inflight} - {2'b00, pop};
      issue    = !reset && (occ < 3'd2);

      if (pend_q) begin
         if (state_q == W2) begin
            new_e.op  = lat_op_q;
            new_e.op2 = pmem_rdata;
            new_e.tw  = 1'b1;
            new_e.pc  = lat_pc_q;
            push      = 1'b1;
            state_d   = W1;
         end else if (is_two(pmem_rdata)) begin
            lat_op_d = pmem_rdata;
            lat_pc_d = pend_pc_q;
            state_d  = W2;
         end else begin
            new_e.op  = pmem_rdata;
            new_e.op2 = 16'h0000;
            new_e.tw  = 1'b0;
            new_e.pc  = pend_pc_q;
            push      = 1'b1;
         end
      end

      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = new_e;
         wr_ptr_d         = ~wr_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      if (issue) begin
         pmem_re      = 1'b1;
         pend_d       = 1'b1;
         pend_pc_d    = fetch_addr_q;
         fetch_addr_d = fetch_addr_q + ONE;
      end

      // A redirect flushes everything, including the word returning now
      if (redirect_valid && !reset) begin
         state_d      = W1;
         count_d      = 2'd0;
         rd_ptr_d     = 1'b0;
         wr_ptr_d     = 1'b0;
         pmem_re      = 1'b1;
         pmem_addr    = redirect_addr;
         pend_d       = 1'b1;
         pend_pc_d    = redirect_addr;
         fetch_addr_d = redirect_addr + ONE;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         state_q      <= W1;
         pend_q       <= 1'b0;
         pend_pc_q    <= '0;
         fetch_addr_q <= RESET_VECTOR;
         lat_pc_q     <= '0;
         lat_op_q     <= '0;
      end else begin
         fifo_q       <= fifo_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         pend_q       <= pend_d;
         pend_pc_q    <= pend_pc_d;
         fetch_addr_q <= fetch_addr_d;
         lat_pc_q     <= lat_pc_d;
         lat_op_q     <= lat_op_d;
      end
   end

endmodule

// File: tb/tb_risc8_fetch.sv
// tb_risc8_fetch: directed bench for risc8_fetch with a program-level
// reference model checking every transfer and hold-stability.
module tb_risc8_fetch;

   localparam int unsigned PB = 8;
   localparam logic [7:0]  RV = 8'h00;

   logic        clk = 1'b0;
   logic        reset;
   logic        out_ready;
   logic        redirect_valid;
   logic [7:0]  redirect_addr;
   logic [7:0]  pmem_addr;
   logic        pmem_re;
   logic [15:0] pmem_rdata;
   logic        out_valid;
   logic [15:0] opcode;
   logic [15:0] opcode2;
   logic        two_word;
   logic [7:0]  pc;
   logic [7:0]  pc_next;

   logic [15:0] mem [256];
   int          errors = 0;
   int          checks = 0;
   int          xfers  = 0;
   int          n;
   int          reads;

   always #5 clk = ~clk;

   risc8_fetch #(.PC_BITS(PB), .RESET_VECTOR(RV)) dut (
      .clk            (clk),
      .reset          (reset),
      .pmem_addr      (pmem_addr),
      .pmem_re        (pmem_re),
      .pmem_rdata     (pmem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .opcode         (opcode),
      .opcode2        (opcode2),
      .two_word       (two_word),
      .pc             (pc),
      .pc_next        (pc_next),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr)
   );

   // Program memory: data valid the cycle after the strobe
   always @(posedge clk) begin
      pmem_rdata <= pmem_re ? mem[pmem_addr] : 16'hFFFF;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic tw_of(input logic [15:0] w);
      return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
   endfunction

   // Reference model: the consumer must see the program walked in order
   logic [7:0]  exp_pc;
   logic        stall_prev;
   logic [48:0] hold;
   logic [15:0] e_op;
   logic [15:0] e_op2;
   logic        e_tw;
   logic [7:0]  e_nx;

   always @(negedge clk) begin
      if (reset) begin
         exp_pc     = RV;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("hold", {opcode, opcode2, two_word, pc, pc_next}, hold);
         if (out_valid && out_ready) begin
            e_op  = mem[exp_pc];
            e_tw  = tw_of(e_op);
            e_op2 = e_tw ? mem[exp_pc + 8'd1] : 16'h0000;
            e_nx  = exp_pc + (e_tw ? 8'd2 : 8'd1);
            chk("xfer", {opcode, opcode2, two_word, pc, pc_next},
                {e_op, e_op2, e_tw, exp_pc, e_nx});
            exp_pc = e_nx;
            xfers++;
         end
         stall_prev = out_valid && !out_ready;
         hold       = {opcode, opcode2, two_word, pc, pc_next};
         if (redirect_valid) begin
            exp_pc     = redirect_addr;
            stall_prev = 1'b0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic rst_on(input logic rdy);
      cyc();
      reset          = 1'b1;
      out_ready      = rdy;
      redirect_valid = 1'b0;
   endtask

   task automatic rel();
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic fill_single();
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000 | 16'(i);
      mem[0] = 16'hE00F;
      mem[1] = 16'hE010;
      mem[2] = 16'h0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      fill_single();
      reset          = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr  = 8'h00;

      // Reset state, first read, single-word stream
      repeat (3) cyc();
      smp();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_re", pmem_re, 1'b0);
      chk("rst_fields", {opcode, opcode2, pc, pc_next}, 48'h0);
      cyc();
      reset = 1'b0;
      smp();
      chk("first_rd", {pmem_re, pmem_addr}, {1'b1, RV});
      chk("first_vld", out_valid, 1'b0);
      cyc(); smp();
      chk("lat_vld", out_valid, 1'b0);
      cyc(); smp();
      chk("a_op0", {out_valid, opcode, pc}, {1'b1, 16'hE00F, 8'h00});
      cyc(); smp();
      chk("a_op1", {out_valid, opcode, pc}, {1'b1, 16'hE010, 8'h01});
      cyc(); smp();
      chk("a_op2", {out_valid, opcode, pc}, {1'b1, 16'h0000, 8'h02});
      n = 0;
      repeat (8) begin cyc(); smp(); if (out_valid) n++; end
      chk("a_rate", n, 8);

      // Two-word JMP stream
      rst_on(1'b1);
      for (int k = 0; k < 32; k++) begin
         mem[2*k]   = 16'h940C;
         mem[2*k+1] = 16'h0100 | 16'(k);
      end
      mem[1] = 16'h0123;
      rel();
      smp();
      cyc(); smp();
      chk("b_lat1", out_valid, 1'b0);
      cyc(); smp();
      chk("b_lat2", out_valid, 1'b0);
      cyc(); smp();
      chk("b_jmp", {out_valid, opcode, opcode2, two_word, pc, pc_next},
          {1'b1, 16'h940C, 16'h0123, 1'b1, 8'h00, 8'h02});
      n = 0;
      repeat (8) begin cyc(); smp(); if (out_valid) n++; end
      chk("b_rate", n, 4);

      // Backpressure
      rst_on(1'b0);
      fill_single();
      rel();
      smp();
      reads = pmem_re ? 1 : 0;
      for (int i = 0; i < 10 && !out_valid; i++) begin
         cyc(); smp();
         if (pmem_re) reads++;
      end
      chk("c_seen", out_valid, 1'b1);
      repeat (5) begin
         cyc(); smp();
         if (pmem_re) reads++;
         chk("c_head", {out_valid, opcode, pc}, {1'b1, 16'hE00F, 8'h00});
      end
      chk("c_reads", reads <= 2, 1'b1);
      cyc();
      out_ready = 1'b1;
      smp();
      chk("c_pc0", {out_valid, pc}, {1'b1, 8'h00});
      cyc(); smp();
      chk("c_pc1", {out_valid, pc}, {1'b1, 8'h01});
      cyc(); smp();
      chk("c_pc2", {out_valid, pc}, {1'b1, 8'h02});

      // Redirect while stalled in W2 with no room
      rst_on(1'b0);
      fill_single();
      mem[1]    = 16'h940C;
      mem[2]    = 16'h0077;
      mem[8'h40] = 16'hE123;
      mem[8'h50] = 16'h9000;
      mem[8'h51] = 16'h0ABC;
      rel();
      repeat (5) cyc();
      smp();
      chk("d_stuck", {out_valid, opcode, pmem_re}, {1'b1, 16'hE00F, 1'b0});
      cyc();
      redirect_valid = 1'b1;
      redirect_addr  = 8'h40;
      out_ready      = 1'b1;
      smp();
      chk("d_rd", {pmem_re, pmem_addr}, {1'b1, 8'h40});
      cyc();
      redirect_valid = 1'b0;
      smp();
      chk("d_gap", out_valid, 1'b0);
      cyc(); smp();
      chk("d_tgt", {out_valid, opcode, pc}, {1'b1, 16'hE123, 8'h40});
      repeat (4) begin cyc(); smp(); end

      // Redirect to a two-word target with a read outstanding
      cyc();
      redirect_valid = 1'b1;
      redirect_addr  = 8'h50;
      smp();
      cyc();
      redirect_valid = 1'b0;
      smp();
      chk("e_gap1", out_valid, 1'b0);
      cyc(); smp();
      chk("e_gap2", out_valid, 1'b0);
      cyc(); smp();
      chk("e_tgt", {out_valid, opcode, opcode2, two_word, pc, pc_next},
          {1'b1, 16'h9000, 16'h0ABC, 1'b1, 8'h50, 8'h52});
      cyc(); smp();

      // Address wrap between the two words of one instruction
      cyc();
      mem[8'hFF] = 16'h940C;
      mem[8'h00] = 16'h0155;
      smp();
      cyc();
      redirect_valid = 1'b1;
      redirect_addr  = 8'hFF;
      smp();
      chk("w_rd", {pmem_re, pmem_addr}, {1'b1, 8'hFF});
      cyc();
      redirect_valid = 1'b0;
      smp();
      chk("w_rd0", {pmem_re, pmem_addr}, {1'b1, 8'h00});
      cyc(); smp();
      cyc(); smp();
      chk("w_ins", {out_valid, opcode, opcode2, two_word, pc, pc_next},
          {1'b1, 16'h940C, 16'h0155, 1'b1, 8'hFF, 8'h01});
      repeat (3) begin cyc(); smp(); end

      // Reset pulsed mid-stream, at two assembler phases
      for (int k = 0; k < 8; k++) begin
         mem[8'h60 + 2*k] = 16'h940C;
         mem[8'h61 + 2*k] = 16'h0200 | 16'(k);
      end
      for (int ph = 0; ph < 2; ph++) begin
         cyc();
         redirect_valid = 1'b1;
         redirect_addr  = 8'h60;
         cyc();
         redirect_valid = 1'b0;
         repeat (3 + ph) cyc();
         cyc();
         reset = 1'b1;
         smp();
         chk("f_rst", {out_valid, pmem_re}, 2'b00);
         cyc();
         reset = 1'b0;
         smp();
         chk("f_rd", {pmem_re, pmem_addr}, {1'b1, RV});
         cyc(); smp();
         chk("f_gap", out_valid, 1'b0);
         cyc(); smp();
         chk("f_first", {out_valid, opcode, pc}, {1'b1, 16'h0155, 8'h00});
      end

      repeat (4) begin cyc(); smp(); end
      chk("xfer_count", xfers >= 20, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
